// File: rtl/fish_pkg.sv
// ============================================================================
// Module   : fish_pkg
// Brief    : Shared types and default screen/sprite constants for the fish
//            movement generator, position tracker and renderer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fish_pkg;

  // Life-cycle state of one fish
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWIM   = 2'd1,
    ST_CAUGHT = 2'd2
  } state_e;

  // Swim direction chosen at spawn
  typedef enum logic [1:0] {
    WAY_LEFT  = 2'd0,
    WAY_RIGHT = 2'd1,
    WAY_UP    = 2'd2,
    WAY_RSVD  = 2'd3
  } way_e;

  localparam int DEF_H_MAX  = 640;
  localparam int DEF_V_MAX  = 480;
  localparam int DEF_FISH_W = 32;
  localparam int DEF_FISH_H = 16;

endpackage

`default_nettype wire

// File: rtl/fish_hit_check.sv
// ============================================================================
// Module   : fish_hit_check
// Brief    : Combinational box-contains-point test. The box spans
//            [x, x+w) by [y, y+h); one extra bit keeps the right/bottom
//            edge sums from wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fish_hit_check #(
  parameter int W = 10
) (
  input  logic [W-1:0] box_x_i,
  input  logic [W-1:0] box_y_i,
  input  logic [W-1:0] box_w_i,
  input  logic [W-1:0] box_h_i,
  input  logic [W-1:0] pt_x_i,
  input  logic [W-1:0] pt_y_i,
  output logic         hit_o
);

  logic [W:0] w_x_end;
  logic [W:0] w_y_end;

  assign w_x_end = {1'b0, box_x_i} + {1'b0, box_w_i};
  assign w_y_end = {1'b0, box_y_i} + {1'b0, box_h_i};

  assign hit_o = (pt_x_i >= box_x_i) && ({1'b0, pt_x_i} < w_x_end) &&
                 (pt_y_i >= box_y_i) && ({1'b0, pt_y_i} < w_y_end);

endmodule

`default_nettype wire

// File: rtl/fish_pos_tracker.sv
// ============================================================================
// Module   : fish_pos_tracker
// Brief    : Integrates movement-generator step pulses into a registered fish
//            position and runs the spawn/swim/hooked/reel-in/escape cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fish_pos_tracker
  import fish_pkg::*;
#(
  parameter int H_MAX  = DEF_H_MAX,
  parameter int V_MAX  = DEF_V_MAX,
  parameter int FISH_W = DEF_FISH_W,
  parameter int FISH_H = DEF_FISH_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       appear,
  input  logic [1:0] way,
  input  logic [9:0] spawn_pos,
  input  logic [2:0] hm,
  input  logic [2:0] vm,
  input  logic [9:0] hook_x,
  input  logic [9:0] hook_y,
  input  logic       reel_step,
  output logic [9:0] fish_x,
  output logic [9:0] fish_y,
  output logic       active,
  output logic [1:0] state,
  output logic       caught,
  output logic       escaped,
  output logic       landed
);

  // Largest legal top-left coordinates
  localparam logic [9:0] X_LIM = 10'(H_MAX - FISH_W);
  localparam logic [9:0] Y_LIM = 10'(V_MAX - FISH_H);

  state_e     state_q, state_d;
  way_e       way_q, way_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       appear_q;
  logic       active_q, caught_q, escaped_q, landed_q;
  logic       caught_d, escaped_d, landed_d;

  logic        w_spawn;
  logic        w_hit;
  logic        w_step;
  logic [10:0] w_hm11;
  logic [10:0] w_x_right;
  logic [10:0] w_y_drift;
  logic [9:0]  w_y_clamp;

  assign w_spawn   = appear & ~appear_q;
  assign w_step    = (hm != 3'd0) || (vm != 3'd0);
  assign w_hm11    = {8'd0, hm};
  assign w_x_right = {1'b0, x_q} + w_hm11;
  assign w_y_drift = {1'b0, y_q} + {8'd0, vm};
  assign w_y_clamp = (w_y_drift > {1'b0, Y_LIM}) ? Y_LIM : w_y_drift[9:0];

  fish_hit_check #(.W(10)) u_hit (
    .box_x_i (x_q),
    .box_y_i (y_q),
    .box_w_i (10'(FISH_W)),
    .box_h_i (10'(FISH_H)),
    .pt_x_i  (hook_x),
    .pt_y_i  (hook_y),
    .hit_o   (w_hit)
  );

  // Next state, next position and event pulses
  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    x_d       = x_q;
    y_d       = y_q;
    caught_d  = 1'b0;
    escaped_d = 1'b0;
    landed_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_spawn && (way != WAY_RSVD)) begin
          state_d = ST_SWIM;
          way_d   = way_e'(way);
          case (way_e'(way))
            WAY_LEFT:  begin x_d = X_LIM;     y_d = spawn_pos; end
            WAY_RIGHT: begin x_d = 10'd0;     y_d = spawn_pos; end
            default:   begin x_d = spawn_pos; y_d = Y_LIM;     end
          endcase
        end
      end
      ST_SWIM: begin
        if (!appear) begin
          state_d = ST_IDLE;
        end else if (w_hit) begin
          state_d  = ST_CAUGHT;
          caught_d = 1'b1;
        end else if (w_step) begin
          case (way_q)
            WAY_LEFT: begin
              if ({1'b0, x_q} < w_hm11) begin
                state_d   = ST_IDLE;
                escaped_d = 1'b1;
              end else begin
                x_d = x_q - {7'd0, hm};
                y_d = w_y_clamp;
              end
            end
            WAY_RIGHT: begin
              if (w_x_right > {1'b0, X_LIM}) begin
                state_d   = ST_IDLE;
                escaped_d = 1'b1;
              end else begin
                x_d = x_q + {7'd0, hm};
                y_d = w_y_clamp;
              end
            end
            WAY_UP: begin
              if ({1'b0, y_q} < w_hm11) begin
                state_d   = ST_IDLE;
                escaped_d = 1'b1;
              end else begin
                y_d = y_q - {7'd0, hm};
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_CAUGHT: begin
        if (!appear) begin
          state_d = ST_IDLE;
        end else if (reel_step) begin
          if (y_q == 10'd0) begin
            state_d  = ST_IDLE;
            landed_d = 1'b1;
          end else begin
            y_d = y_q - 10'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, position and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      way_q     <= WAY_LEFT;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      appear_q  <= 1'b0;
      active_q  <= 1'b0;
      caught_q  <= 1'b0;
      escaped_q <= 1'b0;
      landed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      way_q     <= way_d;
      x_q       <= x_d;
      y_q       <= y_d;
      appear_q  <= appear;
      active_q  <= (state_d != ST_IDLE);
      caught_q  <= caught_d;
      escaped_q <= escaped_d;
      landed_q  <= landed_d;
    end
  end

  assign fish_x  = x_q;
  assign fish_y  = y_q;
  assign state   = state_q;
  assign active  = active_q;
  assign caught  = caught_q;
  assign escaped = escaped_q;
  assign landed  = landed_q;

endmodule

`default_nettype wire

// File: tb/tb_fish_pos_tracker.sv
// ============================================================================
// Module   : tb_fish_pos_tracker
// Brief    : Directed self-checking bench for fish_pos_tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fish_pos_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       appear;
  logic [1:0] way;
  logic [9:0] spawn_pos;
  logic [2:0] hm;
  logic [2:0] vm;
  logic [9:0] hook_x;
  logic [9:0] hook_y;
  logic       reel_step;
  logic [9:0] fish_x;
  logic [9:0] fish_y;
  logic       active;
  logic [1:0] state;
  logic       caught;
  logic       escaped;
  logic       landed;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fish_pos_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .appear    (appear),
    .way       (way),
    .spawn_pos (spawn_pos),
    .hm        (hm),
    .vm        (vm),
    .hook_x    (hook_x),
    .hook_y    (hook_y),
    .reel_step (reel_step),
    .fish_x    (fish_x),
    .fish_y    (fish_y),
    .active    (active),
    .state     (state),
    .caught    (caught),
    .escaped   (escaped),
    .landed    (landed)
  );

  // Advance one clock edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the full observable status against expectations
  task automatic expect_all(input string name, input logic [1:0] st,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic act, input logic c, input logic e,
                            input logic l);
    vectors++;
    if ({state, fish_x, fish_y, active, caught, escaped, landed} !==
        {st, x, y, act, c, e, l}) begin
      miscompares++;
      $display("FAIL %s: got st=%0d x=%0d y=%0d act=%b c=%b e=%b l=%b, want st=%0d x=%0d y=%0d act=%b c=%b e=%b l=%b",
               name, state, fish_x, fish_y, active, caught, escaped, landed,
               st, x, y, act, c, e, l);
    end
  endtask

  task automatic idle_inputs();
    appear = 1'b0; hm = 3'd0; vm = 3'd0; reel_step = 1'b0;
    hook_x = 10'd1023; hook_y = 10'd1023;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; appear = 1'b0; way = 2'd0; spawn_pos = 10'd0;
    hm = 3'd0; vm = 3'd0; hook_x = 10'd1023; hook_y = 10'd1023; reel_step = 1'b0;
    step(); step();
    expect_all("reset", 2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    expect_all("after_release", 2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_right_escape();
    idle_inputs();
    way = 2'd1; spawn_pos = 10'd100; appear = 1'b1;
    step();
    expect_all("right_spawn", 2'd1, 10'd0, 10'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    hm = 3'd1;
    for (int i = 1; i <= 608; i++) begin
      step();
      vectors++;
      if (fish_x !== 10'(i) || fish_y !== 10'd100 || state !== 2'd1) begin
        miscompares++;
        $display("FAIL right_step%0d: got x=%0d y=%0d st=%0d, want x=%0d y=100 st=1",
                 i, fish_x, fish_y, state, i);
      end
    end
    step();
    expect_all("right_escape", 2'd0, 10'd608, 10'd100, 1'b0, 1'b0, 1'b1, 1'b0);
    hm = 3'd0;
    step();
    expect_all("escape_one_cycle", 2'd0, 10'd608, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    expect_all("no_respawn_held", 2'd0, 10'd608, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_left_drift();
    idle_inputs();
    way = 2'd0; spawn_pos = 10'd460; appear = 1'b1;
    step();
    expect_all("left_spawn", 2'd1, 10'd608, 10'd460, 1'b1, 1'b0, 1'b0, 1'b0);
    hm = 3'd2; vm = 3'd4;
    step();
    expect_all("left_step1_clamp", 2'd1, 10'd606, 10'd464, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    expect_all("left_step2_clamp", 2'd1, 10'd604, 10'd464, 1'b1, 1'b0, 1'b0, 1'b0);
    hm = 3'd0; vm = 3'd0;
    appear = 1'b0;
    step();
    expect_all("despawn_no_pulse", 2'd0, 10'd604, 10'd464, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_up_escape();
    idle_inputs();
    way = 2'd2; spawn_pos = 10'd300; appear = 1'b1;
    step();
    expect_all("up_spawn", 2'd1, 10'd300, 10'd464, 1'b1, 1'b0, 1'b0, 1'b0);
    hm = 3'd7; vm = 3'd5;
    step();
    expect_all("up_step_vm_ignored", 2'd1, 10'd300, 10'd457, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65; i++) step();
    // 457 - 65*7 = 2, so the next step of 7 escapes
    expect_all("up_near_top", 2'd1, 10'd300, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    expect_all("up_escape", 2'd0, 10'd300, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    hm = 3'd0; vm = 3'd0;
  endtask

  task automatic test_hit();
    idle_inputs();
    way = 2'd1; spawn_pos = 10'd200; appear = 1'b1;
    step();
    hm = 3'd1;
    for (int i = 0; i < 50; i++) step();
    hm = 3'd0;
    expect_all("hit_setup", 2'd1, 10'd50, 10'd200, 1'b1, 1'b0, 1'b0, 1'b0);
    hook_x = 10'd82; hook_y = 10'd210;
    step();
    expect_all("hit_right_edge_miss", 2'd1, 10'd50, 10'd200, 1'b1, 1'b0, 1'b0, 1'b0);
    hook_x = 10'd60; hook_y = 10'd216;
    step();
    expect_all("hit_bottom_edge_miss", 2'd1, 10'd50, 10'd200, 1'b1, 1'b0, 1'b0, 1'b0);
    hook_x = 10'd60; hook_y = 10'd210; hm = 3'd1;
    step();
    expect_all("hit_caught", 2'd2, 10'd50, 10'd200, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("caught_frozen", 2'd2, 10'd50, 10'd200, 1'b1, 1'b0, 1'b0, 1'b0);
    hm = 3'd0;
    appear = 1'b0;
    step();
    expect_all("caught_despawn", 2'd0, 10'd50, 10'd200, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reel();
    idle_inputs();
    way = 2'd1; spawn_pos = 10'd3; appear = 1'b1;
    hook_x = 10'd10; hook_y = 10'd5;
    step();
    expect_all("reel_spawn", 2'd1, 10'd0, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    expect_all("reel_caught", 2'd2, 10'd0, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    hook_x = 10'd1023; hook_y = 10'd1023;
    for (int i = 2; i >= 0; i--) begin
      reel_step = 1'b1;
      step();
      reel_step = 1'b0;
      expect_all("reel_up", 2'd2, 10'd0, 10'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    reel_step = 1'b1;
    step();
    reel_step = 1'b0;
    expect_all("reel_landed", 2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    expect_all("landed_one_cycle", 2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reserved_way();
    idle_inputs();
    way = 2'd3; spawn_pos = 10'd77; appear = 1'b1;
    step();
    expect_all("way3_ignored", 2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_all("way3_still_idle", 2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    idle_inputs();
    way = 2'd0; spawn_pos = 10'd40; appear = 1'b1;
    hook_x = 10'd620; hook_y = 10'd50;
    step();
    step();
    expect_all("ar_caught", 2'd2, 10'd608, 10'd40, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_all("ar_immediate", 2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    appear = 1'b0; hook_x = 10'd1023; hook_y = 10'd1023;
    step();
    @(negedge clk);
    rst = 1'b0;
    way = 2'd1; spawn_pos = 10'd123; appear = 1'b1;
    step();
    expect_all("ar_respawn", 2'd1, 10'd0, 10'd123, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_right_escape();
    test_left_drift();
    test_up_escape();
    test_hit();
    test_reel();
    test_reserved_way();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fish_pos_tracker.md
# fish_pos_tracker

Integrates the per-tick step pulses (`hm`, `vm`) produced by a fish movement generator into an on-screen fish position. It also runs the fish life cycle: spawn, swim, hooked, reel-in, and escape. It sits between one fish's movement generator and the VGA pixel renderer / score logic. It publishes registered coordinates plus one-cycle `caught` / `escaped` / `landed` event pulses.

## Interface
Parameters:
- `H_MAX`, 640, visible width in px
- `V_MAX`, 480, visible height in px
- `FISH_W`, 32, fish sprite width in px
- `FISH_H`, 16, fish sprite height in px

Ports:
- `clk`  in  1  system clock (same domain as the movement generator)
- `rst`  in  1  reset, asynchronous, active-high
- `appear`  in  1  fish-exists level; a rising edge spawns the fish
- `way`  in  2  swim direction: 0 left, 1 right, 2 up, 3 reserved; sampled at spawn only
- `spawn_pos`  in  10  spawn y for way 0/1, spawn x for way 2
- `hm`  in  3  primary step in px; nonzero means a step this cycle
- `vm`  in  3  downward drift step in px (way 0/1 only)
- `hook_x`  in  10  hook tip x
- `hook_y`  in  10  hook tip y
- `reel_step`  in  1  one-cycle pulse; raises a caught fish 1 px
- `fish_x`  out  10  fish top-left x
- `fish_y`  out  10  fish top-left y
- `active`  out  1  high in SWIM or CAUGHT
- `state`  out  2  0 IDLE, 1 SWIM, 2 CAUGHT
- `caught`  out  1  one-cycle pulse on SWIM→CAUGHT
- `escaped`  out  1  one-cycle pulse on leaving the screen
- `landed`  out  1  one-cycle pulse when reel-in completes

## Operation
- `appear_d` is a registered copy of `appear`. `spawn` = `appear & ~appear_d`.
- **IDLE**
  - On `spawn` with `way`≠3, go to SWIM and latch `way`.
  - Spawn position:
    - way 0: x=`H_MAX-FISH_W`, y=`spawn_pos`
    - way 1: x=0, y=`spawn_pos`
    - way 2: x=`spawn_pos`, y=`V_MAX-FISH_H`
  - `way`=3 is ignored; the block stays in IDLE.
- **SWIM**, evaluated each cycle in this priority order:
  1. `appear`=0: go to IDLE. No pulse.
  2. Hit: `hook_x∈[x,x+FISH_W)` and `hook_y∈[y,y+FISH_H)` on the current registered position.
     - Go to CAUGHT and pulse `caught`.
     - Step inputs are ignored that cycle.
  3. Step (`hm`≠0 or `vm`≠0), by latched way:
     - left: if `x<hm`, escape; else x-=hm.
     - right: if `x+hm>H_MAX-FISH_W`, escape; else x+=hm.
     - up: if `y<hm`, escape; else y-=hm. `vm` is ignored.
     - way 0/1: y+=vm, clamped at `V_MAX-FISH_H`.
     - Escape means: go to IDLE and pulse `escaped`.
- **CAUGHT**
  - x is frozen; `hm`/`vm` are ignored.
  - On `reel_step`: if y=0, pulse `landed` and go to IDLE; else y-=1.
  - `appear`=0 also returns to IDLE, with no pulse.
- **Arithmetic**
  - Bounds comparisons use 11-bit unsigned math, so there is no wrap.
  - Positions never leave `[0,H_MAX-FISH_W]` × `[0,V_MAX-FISH_H]`.
- **On entering IDLE**, `fish_x`/`fish_y` keep their last value. Renderers must gate on `active`.

## Timing
- Reset values: `state`=IDLE; `fish_x`=0, `fish_y`=0; `active`, `caught`, `escaped`, `landed` all 0; `appear_d`=0.
- All outputs are registered.
- `appear` rising edge sampled at edge n: SWIM and the spawn position are visible after edge n.
- A step presented in cycle n is reflected in `fish_x`/`fish_y` after edge n (1-cycle latency).
- Event pulses assert for exactly one cycle, coincident with the state change.
- `appear` held high after an escape does not respawn; a new rising edge is required.
- `rst` mid-operation forces IDLE immediately, regardless of state.

## Structure
- `fish_pkg` holds:
  - the state encoding (IDLE/SWIM/CAUGHT)
  - the way codes (LEFT=0, RIGHT=1, UP=2)
  - default screen and sprite constants, shared with the movement generator and renderer
- One combinational sub-module, `fish_hit_check`: box-contains-point test (x, y, w, h, px, py → hit). The renderer reuses it.

## Test plan
- Right-edge escape:
  - Stimulus: `way`=1, `spawn_pos`=100, `appear` rise, then 608 pulses with `hm`=1.
  - Response: x increments 0→608 with y=100. The next pulse gives `escaped`=1 for one cycle, IDLE, and x held at 608.
- Left swim with drift clamp:
  - Stimulus: `way`=0, `spawn_pos`=460, `hm`=2, `vm`=4.
  - Response: after 1 step x=606, y=464 (clamped). After 2 steps x=604, y=464.
- Hit:
  - Stimulus: `way`=1 at x=50, y=200; hook=(60,210) with `hm`=1 the same cycle.
  - Response: `caught` pulse, state=2, x stays 50.
- Reel-in:
  - Stimulus: CAUGHT at y=3, then 4 `reel_step` pulses.
  - Response: y 3→2→1→0; the 4th pulse gives `landed`=1, then IDLE.
- Despawn and reserved way:
  - Stimulus: `appear` falls mid-SWIM; separately, a spawn with `way`=3.
  - Response: despawn gives IDLE with no pulse. `way`=3 stays IDLE with `active`=0.
- Async reset:
  - Stimulus: `rst` asserted mid-CAUGHT, between clock edges.
  - Response: state=0, x=y=0, all pulses 0 immediately. A rising `appear` after release spawns normally.
